// File: rtl/isa_pkg.sv
// Shared ISA definitions for the fetch stage: word type, reset/halt/nop encodings
// and the fetch state encoding.
package isa_pkg;

  typedef logic [15:0] word_t;

  localparam word_t      RESET_PC  = 16'h0000;
  localparam logic [4:0] HALT_OPC  = 5'b00000;
  localparam word_t      NOP_INSTR = 16'h0800;

  typedef enum logic [1:0] {
    FETCH,
    HOLD,
    HALTED
  } fetch_state_t;

  function automatic logic is_halt(input word_t w, input logic [4:0] opc);
    return w[15:11] == opc;
  endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry skid register holding {instr, pc_plus2} for a word accepted while
// decode is stalled. Clear wins over load.
module fetch_skid_buf
  import isa_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        clear,
  input  logic [31:0] din,
  output logic [31:0] dout,
  output logic        full
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout <= 32'h0000_0000;
      full <= 1'b0;
    end else if (clear) begin
      full <= 1'b0;
    end else if (load) begin
      dout <= din;
      full <= 1'b1;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, imem handshake, IF/ID register, stall skid, redirect, HALT.
// Optional misaligned-PC detection is compiled in with FETCH_ALIGN_CHECK_EN.
module fetch_stage #(
  parameter isa_pkg::word_t RESET_PC  = isa_pkg::RESET_PC,
  parameter logic [4:0]     HALT_OPC  = isa_pkg::HALT_OPC,
  parameter isa_pkg::word_t NOP_INSTR = isa_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_rdy,
  input  logic [15:0] imem_data,
  output logic [15:0] instr,
  output logic [15:0] pc_plus2,
  output logic        valid,
  output logic        halted,
  output logic        err
);
  import isa_pkg::*;

  fetch_state_t state, state_next;
  word_t        pc, pc_next;
  logic         misaligned;
  logic         accept;
  logic         halt_word;
  logic [31:0]  fetched;
  logic         skid_load, skid_clear, skid_full;
  logic [31:0]  skid_dout;

`ifdef FETCH_ALIGN_CHECK_EN
  assign misaligned = (state == FETCH) && pc[0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst)             err <= 1'b0;
    else if (redirect)   err <= 1'b0;
    else if (misaligned) err <= 1'b1;
  end
`else
  assign misaligned = 1'b0;
  assign err        = 1'b0;
`endif

  assign imem_req  = (state == FETCH) && !misaligned;
  assign imem_addr = pc;
  assign accept    = imem_req && imem_rdy;
  assign halt_word = is_halt(imem_data, HALT_OPC);
  assign fetched   = {imem_data, pc + 16'd2};
  assign halted    = (state == HALTED);

  // A word accepted under stall parks in the skid; the skid drains once stall drops.
  assign skid_load  = !redirect && stall && accept;
  assign skid_clear = redirect || (!stall && skid_full);

  fetch_skid_buf u_skid (
    .clk   (clk),
    .rst   (rst),
    .load  (skid_load),
    .clear (skid_clear),
    .din   (fetched),
    .dout  (skid_dout),
    .full  (skid_full)
  );

  always_comb begin
    state_next = state;
    pc_next    = pc;
    if (redirect) begin
      state_next = FETCH;
      pc_next    = redirect_pc;
    end else if (accept) begin
      if (halt_word) begin
        state_next = HALTED;
      end else begin
        pc_next = pc + 16'd2;
        if (stall) state_next = HOLD;
      end
    end else if (misaligned) begin
      state_next = HALTED;
    end else if (state == HOLD && !stall) begin
      state_next = FETCH;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= FETCH;
      pc    <= RESET_PC;
    end else begin
      state <= state_next;
      pc    <= pc_next;
    end
  end

  // IF/ID register: redirect flushes, stall holds, otherwise skid first then fresh data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr    <= NOP_INSTR;
      pc_plus2 <= 16'h0000;
      valid    <= 1'b0;
    end else if (redirect) begin
      instr    <= NOP_INSTR;
      pc_plus2 <= 16'h0000;
      valid    <= 1'b0;
    end else if (!stall) begin
      if (skid_full) begin
        {instr, pc_plus2} <= skid_dout;
        valid             <= 1'b1;
      end else if (accept) begin
        {instr, pc_plus2} <= fetched;
        valid             <= 1'b1;
      end else begin
        instr    <= NOP_INSTR;
        pc_plus2 <= 16'h0000;
        valid    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed vector table, hand-written HALT/reset
// sequences, then randomized traffic against a queue-based reference model.
module tb_fetch_stage;
  import isa_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall, redirect, imem_rdy;
  logic [15:0] redirect_pc;
  logic        imem_req;
  logic [15:0] imem_addr, imem_data;
  logic [15:0] instr, pc_plus2;
  logic        valid, halted, err;

  int          tests = 0;
  int          fails = 0;
  logic [15:0] halt_addr = 16'hFFFF;

  always #5 clk = ~clk;

  // Memory image: a non-halt word derived from the address, except one HALT slot.
  function automatic logic [15:0] mem_word(input logic [15:0] a, input logic [15:0] ha);
    if (a == ha) return 16'h0000;
    return 16'h4001 + {1'b0, a[15:1]};
  endfunction

  assign imem_data = mem_word(imem_addr, halt_addr);

  fetch_stage dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rdy    (imem_rdy),
    .imem_data   (imem_data),
    .instr       (instr),
    .pc_plus2    (pc_plus2),
    .valid       (valid),
    .halted      (halted),
    .err         (err)
  );

  typedef struct {
    logic        req;
    logic [15:0] addr;
    logic        vld;
    logic [15:0] ins;
    logic [15:0] pcp2;
    logic        hlt;
    logic        er;
  } exp_t;

  typedef struct {
    logic        st;
    logic        rdy;
    logic        rd;
    logic [15:0] rpc;
    exp_t        e;
  } vec_t;

  function automatic exp_t mk(input logic r, input logic [15:0] a, input logic v,
                              input logic [15:0] i, input logic [15:0] p,
                              input logic h, input logic e);
    exp_t x;
    x.req = r; x.addr = a; x.vld = v; x.ins = i; x.pcp2 = p; x.hlt = h; x.er = e;
    return x;
  endfunction

  function automatic vec_t mkv(input logic st, input logic rdy, input logic rd,
                               input logic [15:0] rpc, input exp_t e);
    vec_t v;
    v.st = st; v.rdy = rdy; v.rd = rd; v.rpc = rpc; v.e = e;
    return v;
  endfunction

  // pc_plus2 only matters while the IF/ID entry is valid.
  task automatic checkOutput(input string name, input exp_t e);
    tests++;
    if (imem_req !== e.req || imem_addr !== e.addr || valid !== e.vld || instr !== e.ins ||
        (e.vld && pc_plus2 !== e.pcp2) || halted !== e.hlt || err !== e.er) begin
      fails++;
      $display("[TB] FAIL %s: got req=%b addr=%h valid=%b instr=%h pc_plus2=%h halted=%b err=%b, want req=%b addr=%h valid=%b instr=%h pc_plus2=%h halted=%b err=%b",
               name, imem_req, imem_addr, valid, instr, pc_plus2, halted, err,
               e.req, e.addr, e.vld, e.ins, e.pcp2, e.hlt, e.er);
    end
  endtask

  task automatic applyStimulus(input logic st, input logic rdy, input logic rd,
                               input logic [15:0] rpc);
    stall = st; imem_rdy = rdy; redirect = rd; redirect_pc = rpc;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Reference model: accepted words enter an in-order queue, decode pops when not stalled.
  logic [15:0] m_pc, m_ins, m_pcp2;
  logic        m_vld, m_halt;
  logic [31:0] m_q[$];

  task automatic modelReset();
    m_pc = 16'h0000; m_q.delete(); m_vld = 1'b0; m_ins = 16'h0800; m_pcp2 = 16'h0000;
    m_halt = 1'b0;
  endtask

  function automatic exp_t modelExpect();
    return mk(!m_halt && m_q.size() == 0, m_pc, m_vld, m_ins, m_pcp2, m_halt, 1'b0);
  endfunction

  task automatic modelStep(input logic st, input logic rdy, input logic rd,
                           input logic [15:0] rpc);
    logic [15:0] w;
    logic [31:0] e;
    if (rd) begin
      m_pc = rpc; m_q.delete(); m_vld = 1'b0; m_ins = 16'h0800; m_pcp2 = 16'h0000;
      m_halt = 1'b0;
    end else begin
      if (!m_halt && m_q.size() == 0 && rdy) begin
        w = mem_word(m_pc, halt_addr);
        m_q.push_back({w, m_pc + 16'd2});
        if (w[15:11] == 5'b00000) m_halt = 1'b1;
        else m_pc = m_pc + 16'd2;
      end
      if (!st) begin
        if (m_q.size() > 0) begin
          e = m_q.pop_front();
          m_ins = e[31:16]; m_pcp2 = e[15:0]; m_vld = 1'b1;
        end else begin
          m_ins = 16'h0800; m_pcp2 = 16'h0000; m_vld = 1'b0;
        end
      end
    end
  endtask

  vec_t tbl[$];

  initial begin
    logic        st, rdy, rd;
    logic [15:0] rpc;

    rst = 1'b1; stall = 1'b0; redirect = 1'b0; imem_rdy = 1'b0; redirect_pc = 16'h0000;

    // Sequential fetch, wait states, stall into skid, redirect under stall+accept.
    tbl.push_back(mkv(0, 1, 0, 16'h0000, mk(1, 16'h0000, 0, 16'h0800, 16'h0000, 0, 0)));
    tbl.push_back(mkv(0, 1, 0, 16'h0000, mk(1, 16'h0002, 1, 16'h4001, 16'h0002, 0, 0)));
    tbl.push_back(mkv(0, 0, 0, 16'h0000, mk(1, 16'h0004, 1, 16'h4002, 16'h0004, 0, 0)));
    tbl.push_back(mkv(0, 0, 0, 16'h0000, mk(1, 16'h0004, 0, 16'h0800, 16'h0000, 0, 0)));
    tbl.push_back(mkv(0, 0, 0, 16'h0000, mk(1, 16'h0004, 0, 16'h0800, 16'h0000, 0, 0)));
    tbl.push_back(mkv(0, 1, 0, 16'h0000, mk(1, 16'h0004, 0, 16'h0800, 16'h0000, 0, 0)));
    tbl.push_back(mkv(1, 1, 0, 16'h0000, mk(1, 16'h0006, 1, 16'h4003, 16'h0006, 0, 0)));
    tbl.push_back(mkv(1, 1, 0, 16'h0000, mk(0, 16'h0008, 1, 16'h4003, 16'h0006, 0, 0)));
    tbl.push_back(mkv(0, 1, 0, 16'h0000, mk(0, 16'h0008, 1, 16'h4003, 16'h0006, 0, 0)));
    tbl.push_back(mkv(0, 1, 0, 16'h0000, mk(1, 16'h0008, 1, 16'h4004, 16'h0008, 0, 0)));
    tbl.push_back(mkv(1, 1, 1, 16'h0100, mk(1, 16'h000A, 1, 16'h4005, 16'h000A, 0, 0)));
    tbl.push_back(mkv(0, 1, 0, 16'h0000, mk(1, 16'h0100, 0, 16'h0800, 16'h0000, 0, 0)));
    tbl.push_back(mkv(0, 0, 0, 16'h0000, mk(1, 16'h0102, 1, 16'h4081, 16'h0102, 0, 0)));
    tbl.push_back(mkv(0, 0, 0, 16'h0000, mk(1, 16'h0102, 0, 16'h0800, 16'h0000, 0, 0)));

    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      checkOutput($sformatf("vec%0d", i), tbl[i].e);
      applyStimulus(tbl[i].st, tbl[i].rdy, tbl[i].rd, tbl[i].rpc);
    end

    // HALT word at 0x0010 delivered once, then idle until redirect to 0x0020.
    halt_addr = 16'h0010;
    applyStimulus(0, 1, 1, 16'h000C);
    checkOutput("halt_redir", mk(1, 16'h000C, 0, 16'h0800, 16'h0000, 0, 0));
    applyStimulus(0, 1, 0, 16'h0000);
    checkOutput("halt_f1", mk(1, 16'h000E, 1, 16'h4007, 16'h000E, 0, 0));
    applyStimulus(0, 1, 0, 16'h0000);
    checkOutput("halt_f2", mk(1, 16'h0010, 1, 16'h4008, 16'h0010, 0, 0));
    applyStimulus(0, 1, 0, 16'h0000);
    checkOutput("halt_deliver", mk(0, 16'h0010, 1, 16'h0000, 16'h0012, 1, 0));
    applyStimulus(0, 1, 0, 16'h0000);
    checkOutput("halt_idle", mk(0, 16'h0010, 0, 16'h0800, 16'h0000, 1, 0));
    applyStimulus(0, 1, 0, 16'h0000);
    checkOutput("halt_stay", mk(0, 16'h0010, 0, 16'h0800, 16'h0000, 1, 0));
    applyStimulus(0, 1, 1, 16'h0020);
    checkOutput("halt_exit", mk(1, 16'h0020, 0, 16'h0800, 16'h0000, 0, 0));
    applyStimulus(0, 1, 0, 16'h0000);
    checkOutput("resume", mk(1, 16'h0022, 1, 16'h4011, 16'h0022, 0, 0));

    // Reset asserted between clock edges must take effect immediately.
    #2 rst = 1'b1;
    #1 checkOutput("async_reset", mk(1, 16'h0000, 0, 16'h0800, 16'h0000, 0, 0));
    @(negedge clk);
    rst = 1'b0;

`ifdef FETCH_ALIGN_CHECK_EN
    applyStimulus(0, 1, 1, 16'h0031);
    checkOutput("align_noreq", mk(0, 16'h0031, 0, 16'h0800, 16'h0000, 0, 0));
    applyStimulus(0, 1, 0, 16'h0000);
    checkOutput("align_err", mk(0, 16'h0031, 0, 16'h0800, 16'h0000, 1, 1));
    #2 rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("align_reset", mk(1, 16'h0000, 0, 16'h0800, 16'h0000, 0, 0));
`endif

    halt_addr = 16'h0040;
    modelReset();
    for (int i = 0; i < 400; i++) begin
      st  = ($urandom_range(0, 3) == 0);
      rdy = ($urandom_range(0, 9) < 7);
      rd  = ($urandom_range(0, 15) == 0);
      rpc = 16'($urandom_range(0, 63)) << 1;
      checkOutput($sformatf("rand%0d", i), modelExpect());
      modelStep(st, rdy, rd, rpc);
      applyStimulus(st, rdy, rd, rpc);
    end
    checkOutput("rand_final", modelExpect());

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage directly upstream of the decode stage.
- Owns the PC, issues requests to the instruction memory, and holds the IF/ID pipeline register that feeds decode: the 16-bit instruction plus PC+2, whose top 5 bits form the decode jump address.
- Handles decode back-pressure (stall), branch/jump redirect from execute, and HALT detection.

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.
- HALT_OPC, 5'b00000, instr[15:11] opcode that halts fetch.
- NOP_INSTR, 16'h0800, encoding driven on instr while valid=0.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; asynchronous, active-high.
- stall  in  1  decode cannot accept; IF/ID register holds.
- redirect  in  1  branch/jump taken in execute; flush and refetch.
- redirect_pc  in  16  target PC, sampled when redirect=1.
- imem_req  out  1  fetch request this cycle.
- imem_addr  out  16  fetch address (= pc).
- imem_rdy  in  1  memory returns data this cycle; handshake completes when imem_req&imem_rdy.
- imem_data  in  16  instruction word, valid when imem_rdy.
- instr  out  16  IF/ID instruction to decode.
- pc_plus2  out  16  IF/ID PC+2 of that instruction.
- valid  out  1  IF/ID holds a real instruction.
- halted  out  1  fetch stopped on HALT.
- err  out  1  fetch error (see Optional Feature; else tied 0).

Behaviour:
- Reset (async, any cycle, mid-transaction included):
  - pc=RESET_PC, state=FETCH, skid buffer empty.
  - valid=0, instr=NOP_INSTR, pc_plus2=16'h0000, halted=0, err=0.
  - A pending memory request is abandoned.
- State machine:
  - FETCH: imem_req=1.
  - HOLD: skid buffer full; imem_req=0.
  - HALTED: imem_req=0.
- Accept = imem_req & imem_rdy. On accept: pc <= pc+2, mod 2^16, so 16'hFFFE wraps to 16'h0000.
- Wait states: if imem_rdy=0, imem_req and imem_addr hold steady. No limit on wait cycles.
- IF/ID update when stall=0:
  - Load from the skid buffer if full (buffer empties, HOLD->FETCH).
  - Else load imem_data on accept, valid=1.
  - Else load a bubble: valid=0, instr=NOP_INSTR.
  - pc_plus2 always loads with its instruction.
- IF/ID when stall=1: holds.
  - An accept in the same cycle writes {imem_data, pc+2} into the one-entry skid buffer; FETCH->HOLD.
  - An accept can never occur with the buffer full, because imem_req=0 in HOLD.
- HALT: an accepted word with [15:11]=HALT_OPC is still delivered to IF/ID (directly or via the skid buffer).
  - pc is not incremented; state->HALTED; halted=1 from the next cycle.
  - Only reset or redirect leaves HALTED.
- Redirect (highest priority, overrides stall):
  - pc <= redirect_pc; skid buffer cleared.
  - IF/ID <= bubble (valid=0, instr=NOP_INSTR).
  - state->FETCH; halted=0.
  - Any same-cycle accept is discarded.
  - First fetch at redirect_pc happens the next cycle.
- Latency: with imem_rdy=1 and no stall, an instruction fetched in cycle N appears at instr/valid in cycle N+1. Throughput is 1 per cycle.
- Simultaneous stall, redirect, and accept: redirect behaviour only.

Optional Feature:
- Macro FETCH_ALIGN_CHECK_EN.
- Defined:
  - If pc[0]=1 while in FETCH: imem_req=0.
  - err is set and stays set until reset or redirect.
  - The fetch is treated as HALT: state->HALTED, IF/ID gets a bubble.
- Undefined: err tied 0; pc[0] is ignored (address is passed as-is).

Decomposition:
- Shared package (isa_pkg): HALT_OPC, NOP_INSTR, RESET_PC, the fetch state enum {FETCH, HOLD, HALTED}, and a 16-bit word type.
- One sub-module: fetch_skid_buf, a one-entry 32-bit register {instr, pc_plus2} with load/clear/full.

Test Plan:
- Reset, then imem_rdy=1, memory holding 0x4001, 0x4002, 0x4003 at 0x0000/2/4 -> imem_addr 0,2,4 on consecutive cycles; instr 0x4001, 0x4002, 0x4003 with pc_plus2 2,4,6 starting one cycle after each fetch; valid=1.
- imem_rdy low for 3 cycles at addr 0x0004 -> imem_addr stays 0x0004; valid=0 with NOP 0x0800 for those cycles; pc does not advance.
- stall=1 for 2 cycles while fetching 0x0006 -> IF/ID holds the previous instruction, the 0x0006 word goes to the skid buffer, and imem_req=0. After release, the 0x0006 word appears next cycle, then fetch resumes at 0x0008 with no loss or duplicate.
- redirect=1, redirect_pc=0x0100 coincident with an accept and stall=1 -> next cycle valid=0 and imem_addr=0x0100, skid empty; the discarded word never reaches instr.
- Fetch HALT word 0x0000 at 0x0010 -> delivered once with valid=1; halted=1 the next cycle; imem_req=0 thereafter. Then redirect to 0x0020 -> halted=0 and fetch resumes at 0x0020.
- With FETCH_ALIGN_CHECK_EN: redirect_pc=0x0031 -> err=1 and halted=1 the next cycle with no request issued. Reset clears err.
